// File: rtl/alu_operand_join.sv
`default_nettype none
// ============================================================================
// alu_operand_join : elastic join of up to three operand streams into one
//                    matched operand set for the fabric ALU data inputs.
// Revision: 1.0
// ============================================================================
module alu_operand_join #(
   parameter int NoConfigBits = 2,
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [WIDTH-1:0]      data_in1,
   input  logic [WIDTH-1:0]      data_in2,
   input  logic [WIDTH-1:0]      data_in3,
   input  logic                  valid_in1,
   input  logic                  valid_in2,
   input  logic                  valid_in3,
   output logic                  ready_in1,
   output logic                  ready_in2,
   output logic                  ready_in3,
   output logic [WIDTH-1:0]      data_out1,
   output logic [WIDTH-1:0]      data_out2,
   output logic [WIDTH-1:0]      data_out3,
   output logic                  valid_out,
   input  logic                  ready_out,
   input  logic [NoConfigBits:0] ConfigBits
);

   localparam int              PTR_W  = $clog2(DEPTH);
   localparam int              CNT_W  = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

   logic [2:0]       mask;
   logic [WIDTH-1:0] lane_din  [3];
   logic [WIDTH-1:0] lane_dout [3];
   logic [2:0]       lane_valid_in;
   logic [2:0]       lane_ready;
   logic [2:0]       lane_nonempty;
   logic [2:0]       lane_ok;
   logic             fire;

   assign mask = ConfigBits[2:0];

   assign lane_din[0] = data_in1;
   assign lane_din[1] = data_in2;
   assign lane_din[2] = data_in3;
   assign lane_valid_in = {valid_in3, valid_in2, valid_in1};

   assign ready_in1 = lane_ready[0];
   assign ready_in2 = lane_ready[1];
   assign ready_in3 = lane_ready[2];
   assign data_out1 = lane_dout[0];
   assign data_out2 = lane_dout[1];
   assign data_out3 = lane_dout[2];

   // A disabled lane never blocks the join.
   assign lane_ok   = ~mask | lane_nonempty;
   assign valid_out = ~rst & en & (|mask) & (&lane_ok);
   assign fire      = valid_out & ready_out;

   for (genvar k = 0; k < 3; k++) begin : g_lane
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic             push;
      logic             pop;

      // Disabled lanes swallow their input so upstream never stalls on them.
      assign lane_ready[k]    = rst ? 1'b0
                              : (mask[k] ? (en & (count_q != C_FULL)) : 1'b1);
      assign lane_nonempty[k] = (count_q != '0);
      assign push             = lane_valid_in[k] & lane_ready[k] & mask[k];
      assign pop              = fire & mask[k];
      assign lane_dout[k]     = (!rst && mask[k] && (count_q != '0))
                              ? mem_q[rd_ptr_q] : '0;

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (!mask[k]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem_q[wr_ptr_q] <= lane_din[k];
      end
   end

endmodule
`default_nettype wire
